reset_release_sequencer: RTL and testbench

Staged reset-release sequencer that consumes the fabric-level active-low reset and releases up to eight downstream subsystem resets one at a time. Each stage is held in reset until the previous stage acknowledges it is ready, with a programmable settle delay between stages. The block also supports a software-requested re-sequence. It sits between the fabric reset generator and the Kyber datapath, bus, and peripheral reset domains.

---
 rtl/reset_release_sequencer_if.sv | 32 +++
 rtl/reset_release_sequencer.sv | 171 +++++++++++++++++
 tb/tb_reset_release_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_release_sequencer_if.sv
// Handshake bundle between the reset-release sequencer (master) and the
// downstream reset domains (slave): stage resets, stage acks and status.
interface reset_release_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int IDX_W = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  SOFT_RST_REQ;
  logic [NUM_STAGES-1:0] STAGE_ACK;
  logic [NUM_STAGES-1:0] STAGE_RESET_N;
  logic                  SEQ_DONE;
  logic                  SEQ_ERROR;
  logic [IDX_W-1:0]      ERR_STAGE;

  modport master (
    input  SOFT_RST_REQ,
    input  STAGE_ACK,
    output STAGE_RESET_N,
    output SEQ_DONE,
    output SEQ_ERROR,
    output ERR_STAGE
  );

  modport slave (
    output SOFT_RST_REQ,
    output STAGE_ACK,
    input  STAGE_RESET_N,
    input  SEQ_DONE,
    input  SEQ_ERROR,
    input  ERR_STAGE
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// Staged reset-release sequencer: releases NUM_STAGES resets one at a time in
// ascending order, each after a settle delay and the previous stage's ack.
// Optional ack timeout / ERROR state is built when RESET_SEQ_ACK_TIMEOUT_EN is defined.
module reset_release_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input logic                       CLK,
  input logic                       FABRIC_RESET_N,
  reset_release_sequencer_if.master seq_bus
);
  localparam int IDX_W = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DLY_W = ($clog2(STAGE_DELAY) > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("reset_release_sequencer: NUM_STAGES must be within 2..8");
  end
  if (STAGE_DELAY < 1) begin : g_bad_stage_delay
    $error("reset_release_sequencer: STAGE_DELAY must be at least 1");
  end
  if (ACK_TIMEOUT < 2) begin : g_bad_ack_timeout
    $error("reset_release_sequencer: ACK_TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_HOLD, ST_DELAY, ST_WAIT_ACK, ST_DONE, ST_ERROR, ST_ASSERT
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DLY_W-1:0]      dcnt_q, dcnt_d;
  logic [NUM_STAGES-1:0] rstn_q, rstn_d;
  logic                  done_q, done_d;
  logic [1:0]            sync_q;
  logic                  rst_sync;

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  logic [TMO_W-1:0]      tcnt_q, tcnt_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      errstg_q, errstg_d;
`endif

  // Fabric reset deassertion is synchronized; assertion clears asynchronously.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) sync_q <= 2'b00;
    else                 sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_sync = sync_q[1];

  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      state_q  <= ST_HOLD;
      idx_q    <= '0;
      dcnt_q   <= '0;
      rstn_q   <= '0;
      done_q   <= 1'b0;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      errstg_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dcnt_q   <= dcnt_d;
      rstn_q   <= rstn_d;
      done_q   <= done_d;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      errstg_q <= errstg_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    rstn_d   = rstn_q;
    done_d   = done_q;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    errstg_d = errstg_q;
`endif
    unique case (state_q)
      ST_HOLD: begin
        if (rst_sync) begin
          dcnt_d  = DLY_LOAD;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dcnt_q == '0) begin
          rstn_d[idx_q] = 1'b1;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
          tcnt_d        = '0;
`endif
          state_d       = ST_WAIT_ACK;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // An ack on the final timeout cycle still counts as success.
        if (seq_bus.STAGE_ACK[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            dcnt_d  = DLY_LOAD;
            state_d = ST_DELAY;
          end
        end
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
        else if (tcnt_q == TMO_LAST) begin
          err_d         = 1'b1;
          errstg_d      = idx_q;
          rstn_d[idx_q] = 1'b0;
          state_d       = ST_ERROR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      ST_ASSERT: begin
        if (dcnt_q == '0) begin
          dcnt_d  = DLY_LOAD;
          state_d = ST_DELAY;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    // Re-sequence: drop every stage and restart from stage 0 after a settle delay.
    if ((state_q == ST_DONE
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
         || state_q == ST_ERROR
`endif
        ) && seq_bus.SOFT_RST_REQ) begin
      rstn_d   = '0;
      done_d   = 1'b0;
      idx_d    = '0;
      dcnt_d   = DLY_LOAD;
      state_d  = ST_ASSERT;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      err_d    = 1'b0;
      errstg_d = '0;
`endif
    end
  end

  assign seq_bus.STAGE_RESET_N = rstn_q;
  assign seq_bus.SEQ_DONE      = done_q;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  assign seq_bus.SEQ_ERROR     = err_q;
  assign seq_bus.ERR_STAGE     = errstg_q;
`else
  assign seq_bus.SEQ_ERROR     = 1'b0;
  assign seq_bus.ERR_STAGE     = '0;
`endif
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Testbench for reset_release_sequencer: scenario tasks checked against an
// edge-arithmetic model of release, ack and done timing.
module tb_reset_release_sequencer;
  localparam int NS = 4;
  localparam int D  = 16;
  localparam int T  = 1024;

  logic CLK = 1'b0;
  logic FABRIC_RESET_N;
  int checks = 0;
  int errors = 0;
  int edge_n;
  int rise_e [NS];
  int lag [NS];
  int exp_rel [NS];
  int done_e, err_e, exp_done;
  logic [NS-1:0] prev_rn;
  logic prev_done, prev_err;
  bit ack_tied, req_in_wait1;

  reset_release_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_release_sequencer #(
    .NUM_STAGES(NS), .STAGE_DELAY(D), .ACK_TIMEOUT(T)
  ) dut (
    .CLK(CLK), .FABRIC_RESET_N(FABRIC_RESET_N), .seq_bus(bus)
  );

  always #5 CLK = ~CLK;

  // Model: stage 0 releases at first_rel; each ack is seen lag cycles after
  // the first WAIT_ACK edge; the next stage follows D edges after that.
  task automatic predict(input int first_rel);
    int k;
    exp_rel[0] = first_rel;
    for (int i = 0; i < NS; i++) begin
      k = exp_rel[i] + 1 + lag[i];
      if (i < NS - 1) exp_rel[i+1] = k + D;
      else            exp_done = k;
    end
  endtask

  task automatic set_lags(input int l0, input int l1, input int l2, input int l3);
    lag[0] = l0; lag[1] = l1; lag[2] = l2; lag[3] = l3;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NS; i++) rise_e[i] = -1;
    done_e = -1;
    err_e  = -1;
    prev_rn   = bus.STAGE_RESET_N;
    prev_done = bus.SEQ_DONE;
    prev_err  = bus.SEQ_ERROR;
    bus.STAGE_ACK = ack_tied ? '1 : '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    edge_n++;
    for (int i = 0; i < NS; i++)
      if (bus.STAGE_RESET_N[i] && !prev_rn[i] && rise_e[i] < 0) rise_e[i] = edge_n;
    if (bus.SEQ_DONE && !prev_done && done_e < 0) done_e = edge_n;
    if (bus.SEQ_ERROR && !prev_err && err_e < 0) err_e = edge_n;
    prev_rn   = bus.STAGE_RESET_N;
    prev_done = bus.SEQ_DONE;
    prev_err  = bus.SEQ_ERROR;
    if (!ack_tied)
      for (int i = 0; i < NS; i++)
        bus.STAGE_ACK[i] = (rise_e[i] >= 0) && (edge_n - rise_e[i] >= lag[i]);
    if (req_in_wait1) bus.SOFT_RST_REQ = (rise_e[1] >= 0) && (rise_e[2] < 0);
  endtask

  task automatic do_reset();
    FABRIC_RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    FABRIC_RESET_N = 1'b1;
    edge_n = 0;
    clear_obs();
  endtask

  task automatic run_until_done(input int limit);
    while (done_e < 0 && err_e < 0 && edge_n < limit) step();
  endtask

  task automatic test_reset();
    ack_tied = 1'b1;
    FABRIC_RESET_N = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (bus.STAGE_RESET_N !== '0) begin errors++; $display("FAIL reset_rstn: got %b, expected 0000", bus.STAGE_RESET_N); end
    checks++; if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", bus.SEQ_DONE); end
    checks++; if (bus.SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", bus.SEQ_ERROR); end
    checks++; if (bus.ERR_STAGE !== '0) begin errors++; $display("FAIL reset_err_stage: got %0d, expected 0", bus.ERR_STAGE); end
    do_reset();
    repeat (3 + D - 1) step();
    checks++; if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL early_release: got %b at edge %0d, expected 0000", bus.STAGE_RESET_N, edge_n); end
    step();
    checks++; if (bus.STAGE_RESET_N !== 4'b0001) begin errors++; $display("FAIL first_release: got %b at edge %0d, expected 0001", bus.STAGE_RESET_N, edge_n); end
  endtask

  task automatic test_all_ack_high();
    ack_tied = 1'b1;
    set_lags(0, 0, 0, 0);
    do_reset();
    predict(3 + D);
    run_until_done(400);
    for (int i = 0; i < NS; i++) begin
      checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL all_high rise[%0d]: got edge %0d, expected edge %0d", i, rise_e[i], exp_rel[i]); end
    end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL all_high done: got edge %0d, expected edge %0d", done_e, exp_done); end
    checks++; if (err_e !== -1) begin errors++; $display("FAIL all_high error: got edge %0d, expected none", err_e); end
  endtask

  task automatic test_delayed_ack();
    ack_tied = 1'b0;
    set_lags(0, 100, 0, 0);
    do_reset();
    predict(3 + D);
    run_until_done(1000);
    for (int i = 0; i < NS; i++) begin
      checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL delayed_ack rise[%0d]: got edge %0d, expected edge %0d", i, rise_e[i], exp_rel[i]); end
    end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL delayed_ack done: got edge %0d, expected edge %0d", done_e, exp_done); end
  endtask

  task automatic test_random_lags();
    ack_tied = 1'b0;
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < NS; i++) lag[i] = $urandom_range(0, 30);
      do_reset();
      predict(3 + D);
      run_until_done(2000);
      for (int i = 0; i < NS; i++) begin
        checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL random_lags rep%0d rise[%0d]: got edge %0d, expected edge %0d (lag %0d)", rep, i, rise_e[i], exp_rel[i], lag[i]); end
      end
      checks++; if (done_e !== exp_done) begin errors++; $display("FAIL random_lags rep%0d done: got edge %0d, expected edge %0d", rep, done_e, exp_done); end
      checks++; if (err_e !== -1) begin errors++; $display("FAIL random_lags rep%0d error: got edge %0d, expected none", rep, err_e); end
    end
  endtask

  task automatic test_soft_ignored();
    ack_tied = 1'b0;
    set_lags(0, 40, 0, 0);
    req_in_wait1 = 1'b1;
    do_reset();
    predict(3 + D);
    run_until_done(1000);
    req_in_wait1 = 1'b0;
    bus.SOFT_RST_REQ = 1'b0;
    for (int i = 0; i < NS; i++) begin
      checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL soft_ignored rise[%0d]: got edge %0d, expected edge %0d", i, rise_e[i], exp_rel[i]); end
    end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL soft_ignored done: got edge %0d, expected edge %0d", done_e, exp_done); end
  endtask

  task automatic test_ack_on_timeout_edge();
    ack_tied = 1'b0;
    set_lags(0, 0, T - 1, 0);
    do_reset();
    predict(3 + D);
    run_until_done(exp_done + 50);
    checks++; if (rise_e[3] !== exp_rel[3]) begin errors++; $display("FAIL ack_on_timeout rise[3]: got edge %0d, expected edge %0d", rise_e[3], exp_rel[3]); end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL ack_on_timeout done: got edge %0d, expected edge %0d", done_e, exp_done); end
    checks++; if (err_e !== -1) begin errors++; $display("FAIL ack_on_timeout error: got edge %0d, expected none", err_e); end
  endtask

  task automatic test_timeout();
    ack_tied = 1'b0;
    set_lags(0, 0, 1000000, 0);
    do_reset();
    predict(3 + D);
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
    run_until_done(exp_rel[2] + T + 50);
    checks++; if (err_e !== exp_rel[2] + T) begin errors++; $display("FAIL timeout edge: got edge %0d, expected edge %0d", err_e, exp_rel[2] + T); end
    checks++; if (bus.ERR_STAGE !== 2'd2) begin errors++; $display("FAIL timeout err_stage: got %0d, expected 2", bus.ERR_STAGE); end
    checks++; if (bus.STAGE_RESET_N !== 4'b0011) begin errors++; $display("FAIL timeout rstn: got %b, expected 0011", bus.STAGE_RESET_N); end
    checks++; if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL timeout done: got %b, expected 0", bus.SEQ_DONE); end
`else
    run_until_done(exp_rel[2] + T + 20);
    checks++; if (err_e !== -1 || bus.SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL no_timeout error: got %b (edge %0d), expected 0", bus.SEQ_ERROR, err_e); end
    checks++; if (bus.STAGE_RESET_N !== 4'b0111) begin errors++; $display("FAIL no_timeout rstn: got %b, expected 0111", bus.STAGE_RESET_N); end
    checks++; if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL no_timeout done: got %b, expected 0", bus.SEQ_DONE); end
`endif
    checks++; if (rise_e[2] !== exp_rel[2]) begin errors++; $display("FAIL timeout rise[2]: got edge %0d, expected edge %0d", rise_e[2], exp_rel[2]); end
  endtask

  task automatic test_soft_resequence();
    int r;
`ifndef RESET_SEQ_ACK_TIMEOUT_EN
    lag[2] = 0;
    run_until_done(edge_n + 100);
    checks++; if (bus.SEQ_DONE !== 1'b1) begin errors++; $display("FAIL late_ack done: got %b, expected 1", bus.SEQ_DONE); end
`endif
    bus.SOFT_RST_REQ = 1'b1;
    step();
    r = edge_n;
    bus.SOFT_RST_REQ = 1'b0;
    checks++; if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL soft rstn: got %b, expected 0000", bus.STAGE_RESET_N); end
    checks++; if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL soft done: got %b, expected 0", bus.SEQ_DONE); end
    checks++; if (bus.SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL soft error: got %b, expected 0", bus.SEQ_ERROR); end
    checks++; if (bus.ERR_STAGE !== '0) begin errors++; $display("FAIL soft err_stage: got %0d, expected 0", bus.ERR_STAGE); end
    set_lags(0, 0, 0, 0);
    clear_obs();
    predict(r + 2 * D);
    run_until_done(r + 400);
    for (int i = 0; i < NS; i++) begin
      checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL soft rise[%0d]: got edge %0d, expected edge %0d", i, rise_e[i], exp_rel[i]); end
    end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL soft seq_done: got edge %0d, expected edge %0d", done_e, exp_done); end
  endtask

  task automatic test_fabric_mid_delay();
    ack_tied = 1'b1;
    set_lags(0, 0, 0, 0);
    do_reset();
    predict(3 + D);
    while (edge_n < exp_rel[1] + 6) step();
    checks++; if (bus.STAGE_RESET_N !== 4'b0011) begin errors++; $display("FAIL mid_delay pre rstn: got %b, expected 0011", bus.STAGE_RESET_N); end
    #2;
    FABRIC_RESET_N = 1'b0;
    #1;
    checks++; if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL mid_delay async rstn: got %b, expected 0000", bus.STAGE_RESET_N); end
    do_reset();
    predict(3 + D);
    run_until_done(400);
    for (int i = 0; i < NS; i++) begin
      checks++; if (rise_e[i] !== exp_rel[i]) begin errors++; $display("FAIL mid_delay restart rise[%0d]: got edge %0d, expected edge %0d", i, rise_e[i], exp_rel[i]); end
    end
    checks++; if (done_e !== exp_done) begin errors++; $display("FAIL mid_delay restart done: got edge %0d, expected edge %0d", done_e, exp_done); end
  endtask

  initial begin
    FABRIC_RESET_N   = 1'b0;
    bus.SOFT_RST_REQ = 1'b0;
    bus.STAGE_ACK    = '0;
    ack_tied         = 1'b1;
    req_in_wait1     = 1'b0;
    edge_n           = 0;
    set_lags(0, 0, 0, 0);
    test_reset();
    test_all_ack_high();
    test_delayed_ack();
    test_random_lags();
    test_soft_ignored();
    test_ack_on_timeout_edge();
    test_timeout();
    test_soft_resequence();
    test_fabric_mid_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end
endmodule
